// File: rtl/puf_result_pkg.sv
// puf_result_pkg: state encoding, memory timing and parameter defaults
// shared by the PUF result reader and its testbench.
package puf_result_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        SEND,
        CSUM,
        FIN
    } state_t;

    localparam int MEM_RD_LAT     = 1;
    localparam int DEF_ADDR_W     = 13;
    localparam int DEF_N_RESULTS  = 8;
    localparam int DEF_FIRST_ADDR = 1;

endpackage

// File: rtl/puf_result_reader_if.sv
// puf_result_reader_if: start/memory/stream signals of the PUF result reader.
// The master modport is the reader itself, the slave side is its environment.
interface puf_result_reader_if #(
    parameter int ADDR_W = puf_result_pkg::DEF_ADDR_W
);
    logic              start;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [7:0]        mem_dout;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, mem_dout, out_ready,
        output mem_re, mem_raddr, out_valid, out_data, busy, done
    );

    modport slave (
        output start, mem_dout, out_ready,
        input  mem_re, mem_raddr, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/puf_result_reader_out_reg.sv
// result_out_reg: output byte register; once valid, data is held
// unchanged until the downstream accepts it.
module result_out_reg (
    input  logic       clk_1,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [7:0] o_data
);
    logic       r_valid;
    logic [7:0] r_data;

    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/puf_result_reader.sv
// puf_result_reader: streams N_RESULTS stored PUF bytes from memory to a
// valid/ready sink; PUF_RESULT_READER_CHECKSUM_EN appends a mod-256 sum byte.
module puf_result_reader
    import puf_result_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int N_RESULTS  = DEF_N_RESULTS,
    parameter int FIRST_ADDR = DEF_FIRST_ADDR
) (
    input logic                 clk_1,
    input logic                 rst,
    puf_result_reader_if.master bus
);
    localparam int IDX_W = (N_RESULTS > 1) ? $clog2(N_RESULTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RESULTS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [IDX_W-1:0]  r_idx;
    logic              r_mem_re;
    logic              r_busy;
    logic              r_done;
    logic              w_valid;
    logic [7:0]        w_data;
    logic              w_load;
    logic [7:0]        w_ld_data;
    logic              w_xfer;
`ifdef PUF_RESULT_READER_CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    assign w_xfer = w_valid && bus.out_ready;

    // CSUM spends its first cycle loading the sum, then waits like SEND
    always_comb begin
        w_load    = (r_state == WAIT);
        w_ld_data = bus.mem_dout;
`ifdef PUF_RESULT_READER_CHECKSUM_EN
        if (r_state == CSUM && !w_valid) begin
            w_load    = 1'b1;
            w_ld_data = r_sum;
        end
`endif
    end

    result_out_reg u_out (
        .clk_1   (clk_1),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_ld_data),
        .i_ready (bus.out_ready),
        .o_valid (w_valid),
        .o_data  (w_data)
    );

    always_ff @(posedge clk_1) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_idx    <= '0;
            r_mem_re <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef PUF_RESULT_READER_CHECKSUM_EN
            r_sum    <= 8'h00;
`endif
        end else begin
            r_mem_re <= 1'b0;
            r_done   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state  <= RD;
                        r_mem_re <= 1'b1;
                        r_addr   <= ADDR_W'(FIRST_ADDR);
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
`ifdef PUF_RESULT_READER_CHECKSUM_EN
                        r_sum    <= 8'h00;
`endif
                    end
                end
                RD:   r_state <= WAIT;
                WAIT: r_state <= SEND;
                SEND: begin
                    if (w_xfer) begin
`ifdef PUF_RESULT_READER_CHECKSUM_EN
                        r_sum <= r_sum + w_data;
`endif
                        if (r_idx == LAST_IDX) begin
`ifdef PUF_RESULT_READER_CHECKSUM_EN
                            r_state <= CSUM;
`else
                            r_state <= FIN;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_state  <= RD;
                            r_mem_re <= 1'b1;
                            r_addr   <= r_addr + 1'b1;
                            r_idx    <= r_idx + 1'b1;
                        end
                    end
                end
`ifdef PUF_RESULT_READER_CHECKSUM_EN
                CSUM: begin
                    if (w_xfer) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                    end
                end
`endif
                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_re    = r_mem_re;
    assign bus.mem_raddr = r_addr;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_puf_result_reader.sv
// tb_puf_result_reader: self-checking bench; expected streams come from a
// memory-order model (bytes at FIRST_ADDR+i mod 2^ADDR_W, plus optional sum).
module tb_puf_result_reader;
    import puf_result_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int N1 = DEF_N_RESULTS;
    localparam int F1 = DEF_FIRST_ADDR;
    localparam int N2 = 4;
    localparam int F2 = 8190;
`ifdef PUF_RESULT_READER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk_1 = 1'b0;
    logic rst   = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] obs1[$];
    logic [7:0] obs2[$];
    logic [7:0] exp_b[$];
    int         adr1[$];
    int         adr2[$];
    int         exp_a[$];
    int         done1 = 0;
    int         done2 = 0;
    int         done1_cyc = 0;

    always #5 clk_1 = ~clk_1;

    puf_result_reader_if #(.ADDR_W(AW)) bus1 ();
    puf_result_reader_if #(.ADDR_W(AW)) bus2 ();

    puf_result_reader #(.ADDR_W(AW), .N_RESULTS(N1), .FIRST_ADDR(F1)) dut1 (
        .clk_1 (clk_1),
        .rst   (rst),
        .bus   (bus1)
    );

    puf_result_reader #(.ADDR_W(AW), .N_RESULTS(N2), .FIRST_ADDR(F2)) dut2 (
        .clk_1 (clk_1),
        .rst   (rst),
        .bus   (bus2)
    );

    // Synchronous memory, one cycle of read latency
    always @(posedge clk_1) begin
        if (bus1.mem_re) bus1.mem_dout <= mem[bus1.mem_raddr];
        if (bus2.mem_re) bus2.mem_dout <= mem[bus2.mem_raddr];
    end

    always @(negedge clk_1) begin
        cyc = cyc + 1;
        if (bus1.out_valid && bus1.out_ready) obs1.push_back(bus1.out_data);
        if (bus1.mem_re) adr1.push_back(int'(bus1.mem_raddr));
        if (bus1.done) begin
            done1 = done1 + 1;
            done1_cyc = cyc;
        end
        if (bus2.out_valid && bus2.out_ready) obs2.push_back(bus2.out_data);
        if (bus2.mem_re) adr2.push_back(int'(bus2.mem_raddr));
        if (bus2.done) done2 = done2 + 1;
    end

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic build_exp(input int first, input int n);
        logic [7:0] s;
        s = 8'h00;
        exp_b.delete();
        exp_a.delete();
        for (int i = 0; i < n; i++) begin
            int a;
            a = (first + i) % (1 << AW);
            exp_a.push_back(a);
            exp_b.push_back(mem[AW'(a)]);
            s = s + mem[AW'(a)];
        end
        if (CS == 1) exp_b.push_back(s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.start = 1'b1;
        bus2.start = 1'b1;
        bus1.out_ready = 1'b0;
        bus2.out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk_1);
        checks++;
        if ({bus1.mem_re, bus1.mem_raddr, bus1.out_valid, bus1.out_data,
             bus1.busy, bus1.done} !== '0) begin
            failures++;
            $display("FAIL reset1: got re=%b addr=%0d v=%b d=%h busy=%b done=%b want all 0",
                     bus1.mem_re, bus1.mem_raddr, bus1.out_valid, bus1.out_data,
                     bus1.busy, bus1.done);
        end
        checks++;
        if ({bus2.mem_re, bus2.mem_raddr, bus2.out_valid, bus2.out_data,
             bus2.busy, bus2.done} !== '0) begin
            failures++;
            $display("FAIL reset2: got re=%b addr=%0d v=%b d=%h busy=%b done=%b want all 0",
                     bus2.mem_re, bus2.mem_raddr, bus2.out_valid, bus2.out_data,
                     bus2.busy, bus2.done);
        end
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int d0, sc, bad;
        for (int i = 0; i < N1; i++) mem[AW'(F1 + i)] = 8'(8'h10 + i);
        build_exp(F1, N1);
        bus1.out_ready = 1'b1;
        obs1.delete();
        adr1.delete();
        d0 = done1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        sc = cyc;
        for (int k = 0; k < 400 && done1 == d0; k++) tick();
        tick();
        checks++;
        if (done1 !== d0 + 1) begin
            failures++;
            $display("FAIL basic_done: got %0d pulses want 1", done1 - d0);
        end
        checks++;
        if (done1_cyc !== sc + 3 * N1 + 1 + 2 * CS) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles want %0d",
                     done1_cyc - sc, 3 * N1 + 1 + 2 * CS);
        end
        bad = 0;
        for (int i = 0; i < exp_b.size(); i++)
            if (i >= obs1.size() || obs1[i] !== exp_b[i]) bad++;
        checks++;
        if (bad != 0 || obs1.size() != exp_b.size()) begin
            failures++;
            $display("FAIL basic_bytes: got %p want %p", obs1, exp_b);
        end
        checks++;
        if (adr1 != exp_a) begin
            failures++;
            $display("FAIL basic_addr: got %p want %p", adr1, exp_a);
        end
`ifdef PUF_RESULT_READER_CHECKSUM_EN
        checks++;
        if (obs1.size() < 9 || obs1[8] !== 8'h9C) begin
            failures++;
            $display("FAIL basic_csum: got %p want 9th byte 9c", obs1);
        end
`endif
        checks++;
        if (bus1.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: got busy=%b want 0", bus1.busy);
        end
    endtask

    task automatic test_random_ready();
        int d0, bad;
        logic hold;
        logic [7:0] hd;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N1; i++) mem[AW'(F1 + i)] = 8'($urandom);
            build_exp(F1, N1);
            obs1.delete();
            adr1.delete();
            d0 = done1;
            bus1.out_ready = 1'b0;
            bus1.start = 1'b1;
            tick();
            bus1.start = 1'b0;
            for (int k = 0; k < 800 && done1 == d0; k++) begin
                bus1.out_ready = 1'($urandom_range(0, 1));
                hold = bus1.out_valid && !bus1.out_ready;
                hd = bus1.out_data;
                tick();
                if (hold) begin
                    checks++;
                    if (bus1.out_valid !== 1'b1 || bus1.out_data !== hd) begin
                        failures++;
                        $display("FAIL rand_hold: got v=%b d=%h want v=1 d=%h",
                                 bus1.out_valid, bus1.out_data, hd);
                    end
                end
            end
            tick();
            checks++;
            if (done1 !== d0 + 1) begin
                failures++;
                $display("FAIL rand_done: got %0d pulses want 1", done1 - d0);
            end
            bad = 0;
            for (int i = 0; i < exp_b.size(); i++)
                if (i >= obs1.size() || obs1[i] !== exp_b[i]) bad++;
            checks++;
            if (bad != 0 || obs1.size() != exp_b.size()) begin
                failures++;
                $display("FAIL rand_bytes: got %p want %p", obs1, exp_b);
            end
        end
        bus1.out_ready = 1'b1;
    endtask

    task automatic test_stall();
        int d0, bad;
        for (int i = 0; i < N1; i++) mem[AW'(F1 + i)] = 8'(8'h10 + i);
        build_exp(F1, N1);
        obs1.delete();
        adr1.delete();
        d0 = done1;
        bus1.out_ready = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int k = 0; k < 100 && obs1.size() < 2; k++) tick();
        bus1.out_ready = 1'b0;
        for (int k = 0; k < 20 && !bus1.out_valid; k++) tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_1);
            checks++;
            if (bus1.out_valid !== 1'b1 || bus1.out_data !== 8'h12 ||
                bus1.mem_re !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold: got v=%b d=%h re=%b want v=1 d=12 re=0",
                         bus1.out_valid, bus1.out_data, bus1.mem_re);
            end
        end
        tick();
        bus1.out_ready = 1'b1;
        for (int k = 0; k < 400 && done1 == d0; k++) tick();
        tick();
        bad = 0;
        for (int i = 0; i < exp_b.size(); i++)
            if (i >= obs1.size() || obs1[i] !== exp_b[i]) bad++;
        checks++;
        if (bad != 0 || obs1.size() != exp_b.size() || done1 !== d0 + 1) begin
            failures++;
            $display("FAIL stall_bytes: got %p done=%0d want %p done=1",
                     obs1, done1 - d0, exp_b);
        end
    endtask

    task automatic test_start_busy();
        int d0, bad;
        for (int i = 0; i < N1; i++) mem[AW'(F1 + i)] = 8'($urandom);
        build_exp(F1, N1);
        obs1.delete();
        adr1.delete();
        d0 = done1;
        bus1.out_ready = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int k = 0; k < 400 && done1 == d0; k++) begin
            if (k % 5 == 2 && bus1.busy) begin
                bus1.start = 1'b1;
                tick();
                bus1.start = 1'b0;
            end else begin
                tick();
            end
        end
        repeat (12) tick();
        checks++;
        if (done1 !== d0 + 1 || bus1.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_done: got done=%0d busy=%b want done=1 busy=0",
                     done1 - d0, bus1.busy);
        end
        bad = 0;
        for (int i = 0; i < exp_b.size(); i++)
            if (i >= obs1.size() || obs1[i] !== exp_b[i]) bad++;
        checks++;
        if (bad != 0 || obs1.size() != exp_b.size() || adr1 != exp_a) begin
            failures++;
            $display("FAIL busy_bytes: got %p addr %p want %p addr %p",
                     obs1, adr1, exp_b, exp_a);
        end
    endtask

    task automatic test_reset_mid();
        int d0, bad;
        for (int i = 0; i < N1; i++) mem[AW'(F1 + i)] = 8'($urandom);
        build_exp(F1, N1);
        obs1.delete();
        adr1.delete();
        d0 = done1;
        bus1.out_ready = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int k = 0; k < 100 && obs1.size() < 3; k++) tick();
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk_1);
        checks++;
        if ({bus1.mem_re, bus1.mem_raddr, bus1.out_valid, bus1.out_data,
             bus1.busy, bus1.done} !== '0) begin
            failures++;
            $display("FAIL midrst_zero: got re=%b addr=%0d v=%b d=%h busy=%b done=%b want all 0",
                     bus1.mem_re, bus1.mem_raddr, bus1.out_valid, bus1.out_data,
                     bus1.busy, bus1.done);
        end
        rst = 1'b0;
        repeat (10) tick();
        checks++;
        if (done1 !== d0 || bus1.busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_nodone: got done=%0d busy=%b want done=0 busy=0",
                     done1 - d0, bus1.busy);
        end
        obs1.delete();
        adr1.delete();
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int k = 0; k < 400 && done1 == d0; k++) tick();
        tick();
        bad = 0;
        for (int i = 0; i < exp_b.size(); i++)
            if (i >= obs1.size() || obs1[i] !== exp_b[i]) bad++;
        checks++;
        if (bad != 0 || obs1.size() != exp_b.size() || adr1 != exp_a ||
            done1 !== d0 + 1) begin
            failures++;
            $display("FAIL midrst_replay: got %p addr %p want %p addr %p",
                     obs1, adr1, exp_b, exp_a);
        end
    endtask

    task automatic test_wrap();
        int d0, bad;
        for (int i = 0; i < N2; i++) mem[AW'((F2 + i) % (1 << AW))] = 8'($urandom);
        build_exp(F2, N2);
        obs2.delete();
        adr2.delete();
        d0 = done2;
        bus2.out_ready = 1'b1;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int k = 0; k < 400 && done2 == d0; k++) tick();
        tick();
        checks++;
        if (adr2 != exp_a) begin
            failures++;
            $display("FAIL wrap_addr: got %p want %p", adr2, exp_a);
        end
        bad = 0;
        for (int i = 0; i < exp_b.size(); i++)
            if (i >= obs2.size() || obs2[i] !== exp_b[i]) bad++;
        checks++;
        if (bad != 0 || obs2.size() != exp_b.size() || done2 !== d0 + 1) begin
            failures++;
            $display("FAIL wrap_bytes: got %p done=%0d want %p done=1",
                     obs2, done2 - d0, exp_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_ready();
        test_stall();
        test_start_busy();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1);
    end
endmodule
